addsub_arbiter: RTL and testbench

- Shares one DATA_WIDTH carry-select adder (CSA instance, combinational, no carry-in) between NUM_REQ ODE-solver requesters, such as integrator stages and the error estimator.
- Round-robin arbitration, valid/ready request handshake, registered operand and result stages.
- Subtraction is built in the controller by two's-complement negation of B, with corrected overflow detection.
- Sits between the solver's stage sequencers and the single physical adder.

---
 rtl/addsub_pkg.sv | 36 +++
 rtl/addsub_arbiter_csa.sv | 34 +++
 rtl/addsub_arbiter_rr.sv | 41 ++++
 rtl/addsub_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_addsub_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
//   Shared types and constants for the shared add/subtract arbiter.
//   - state_t  : controller FSM state (IDLE / OPER / DONE), 2-bit encoding
//   - id_width : requester-index width for a given requester count
//   - max_pos / min_neg : signed extremes for a given data width, returned
//     right-aligned in 64 bits so callers can cast them to their own width
// -----------------------------------------------------------------------------
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPER = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single requester still needs a 1-bit index.
  function automatic int id_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

  function automatic logic [63:0] max_pos(input int width);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < width - 1; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] min_neg(input int width);
    logic [63:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/addsub_arbiter_csa.sv
// -----------------------------------------------------------------------------
// csa
//   Combinational carry-select adder, no carry-in. The low half ripples; the
//   high half is evaluated for both carry values and the low-half carry picks
//   one. Also reports two's-complement overflow of the signed sum.
//   Ports:
//     a, b [WIDTH] : signed operands
//     sum  [WIDTH] : a + b modulo 2^WIDTH
//     ovf          : signed overflow (operands agree in sign, sum does not)
// -----------------------------------------------------------------------------
module csa #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam int LO_W = WIDTH / 2;
  localparam int HI_W = WIDTH - LO_W;

  logic [LO_W:0]   lo_sum;
  logic [HI_W-1:0] hi_sum0;
  logic [HI_W-1:0] hi_sum1;

  assign lo_sum  = {1'b0, a[LO_W-1:0]} + {1'b0, b[LO_W-1:0]};
  assign hi_sum0 = a[WIDTH-1:LO_W] + b[WIDTH-1:LO_W];
  assign hi_sum1 = a[WIDTH-1:LO_W] + b[WIDTH-1:LO_W] + HI_W'(1);

  assign sum = {(lo_sum[LO_W] ? hi_sum1 : hi_sum0), lo_sum[LO_W-1:0]};
  assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/addsub_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin grant. The search starts at ptr and wraps
//   modulo NUM_REQ; the first asserted request wins. Also used by the solver's
//   memory-port sharing, so it holds no state of its own.
//   Ports:
//     req   [NUM_REQ] : request vector
//     ptr   [ID_W]    : highest-priority index for this cycle
//     grant [NUM_REQ] : one-hot grant, all zeros when nothing is requested
//     idx   [ID_W]    : encoded index of the grant (0 when none)
//     any             : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // NOTE: every output gets a default before the search loop, so no path
  // through this block can leave a value unassigned and infer a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// -----------------------------------------------------------------------------
// addsub_arbiter
//   Shares one carry-select adder between NUM_REQ requesters. A round-robin
//   grant picks a request in IDLE or DONE, the operands are latched (B is
//   negated for subtraction), the adder evaluates during OPER and the result
//   is registered into DONE, where rsp_valid pulses for one cycle.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     req_valid [NUM_REQ] : per-requester request
//     req_ready [NUM_REQ] : one-hot accept, combinational, zero in OPER
//     req_a/req_b         : packed signed operands, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_sub   [NUM_REQ] : 1 = A-B, 0 = A+B
//     rsp_valid           : one-cycle result strobe
//     rsp_id              : requester owning the result
//     rsp_data            : signed result
//     rsp_overflow        : signed overflow of the operation
//     busy                : controller not idle
//   Build option: define ADDSUB_SATURATE_EN to clamp overflowed results to the
//   signed extremes instead of wrapping.
// -----------------------------------------------------------------------------
import addsub_pkg::*;

module addsub_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]            req_sub,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_overflow,
  output logic                          busy
);

  localparam int MSB = DATA_WIDTH - 1;
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = DATA_WIDTH'(min_neg(DATA_WIDTH));
`ifdef ADDSUB_SATURATE_EN
  localparam logic [DATA_WIDTH-1:0] MAX_POS = DATA_WIDTH'(max_pos(DATA_WIDTH));
`endif

  state_t state, state_nxt;

  logic [ID_W-1:0]       rr_ptr;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       gnt_idx;
  logic                  gnt_any;
  logic                  arb_en;
  logic                  accept;

  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic                  sel_sub;

  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] b_r;
  logic                  sub_r;
  logic                  bmin_r;
  logic [ID_W-1:0]       id_r;

  logic [DATA_WIDTH-1:0] csa_sum;
  logic                  csa_ovf;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_ovf;

  // ---------------------------------------------------------------------------
  // Arbitration: only offered outside OPER and never while reset is asserted,
  // so nothing can appear accepted during reset.
  // ---------------------------------------------------------------------------
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign arb_en    = rst_n && (state != OPER);
  assign req_ready = arb_en ? grant : '0;
  assign accept    = arb_en && gnt_any;

  // One-hot AND-OR operand mux; avoids a variable part-select that could
  // index past the packed bus when NUM_REQ is not a power of two.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a   = sel_a | (req_a[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
      sel_b   = sel_b | (req_b[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[i]}});
      sel_sub = sel_sub | (req_sub[i] & grant[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = OPER;
      OPER:    state_nxt = DONE;
      DONE:    state_nxt = accept ? OPER : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared adder and result correction
  // ---------------------------------------------------------------------------
  csa #(
    .WIDTH (DATA_WIDTH)
  ) u_csa (
    .a   (a_r),
    .b   (b_r),
    .sum (csa_sum),
    .ovf (csa_ovf)
  );

  // Negating MIN yields MIN again, so the adder sees A + MIN and its overflow
  // flag is wrong; the true A - MIN overflows exactly when A is non-negative.
  assign res_ovf = (sub_r && bmin_r) ? ~a_r[MSB] : csa_ovf;

`ifdef ADDSUB_SATURATE_EN
  // On overflow the true result has the sign of A (for a subtraction A and
  // the negated B share that sign), so A's sign picks the clamp value.
  assign res_data = res_ovf ? (a_r[MSB] ? MIN_NEG : MAX_POS) : csa_sum;
`else
  assign res_data = csa_sum;
`endif

  // ---------------------------------------------------------------------------
  // State, pointer, operand and response registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order. The operand
  // registers are cleared on reset as well, so a stale operand can never
  // surface as a response after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      a_r          <= '0;
      b_r          <= '0;
      sub_r        <= 1'b0;
      bmin_r       <= 1'b0;
      id_r         <= '0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr_ptr <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        a_r    <= sel_a;
        b_r    <= sel_sub ? (~sel_b + DATA_WIDTH'(1)) : sel_b;
        sub_r  <= sel_sub;
        bmin_r <= (sel_b == MIN_NEG);
        id_r   <= gnt_idx;
      end
      if (state == OPER) begin
        rsp_id       <= id_r;
        rsp_data     <= res_data;
        rsp_overflow <= res_ovf;
      end
    end
  end

  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// -----------------------------------------------------------------------------
// tb_addsub_arbiter
//   Self-checking bench for addsub_arbiter. A transaction-level reference
//   (signed integer arithmetic, round-robin pointer, response countdown) is
//   compared with the DUT every cycle, plus directed checks against fixed
//   constants for the corner cases. Define ADDSUB_SATURATE_EN on both the
//   bench and the design to exercise the clamping build.
// -----------------------------------------------------------------------------
module tb_addsub_arbiter;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int IW = 2;

  localparam longint MAXV = 32767;
  localparam longint MINV = -32768;

`ifdef ADDSUB_SATURATE_EN
  localparam logic [W-1:0] EXP_SUB_OVF = 16'h7FFF;
  localparam logic [W-1:0] EXP_MIN_OVF = 16'h7FFF;
`else
  localparam logic [W-1:0] EXP_SUB_OVF = 16'h8000;
  localparam logic [W-1:0] EXP_MIN_OVF = 16'h8000;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [N-1:0]    req_sub;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_data;
  logic            rsp_overflow;
  logic            busy;

  addsub_arbiter #(
    .DATA_WIDTH (W),
    .NUM_REQ    (N),
    .ID_W       (IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_sub      (req_sub),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_data     (rsp_data),
    .rsp_overflow (rsp_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: pointer, cycles since last accept (0 = idle,
  // 1 = computing, 2 = result showing), and the pending expected result.
  int           m_ptr   = 0;
  int           m_phase = 0;
  int           m_id    = 0;
  logic [W-1:0] m_data  = '0;
  logic         m_ovf   = 1'b0;
  int           grant_log[$];

  int           last_id;
  logic [W-1:0] last_data;
  logic         last_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Mathematical result of A +/- B with signed range test.
  task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output logic [W-1:0] d, output logic ovf);
    longint      sa, sb, t;
    logic [63:0] tt;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    t   = sub ? (sa - sb) : (sa + sb);
    ovf = (t > MAXV) || (t < MINV);
    tt  = t;
    d   = tt[W-1:0];
`ifdef ADDSUB_SATURATE_EN
    if (ovf) d = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corners[4];
    corners = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
    if ($urandom_range(3) == 0) return corners[$urandom_range(3)];
    return W'($urandom);
  endfunction

  // One clock: check outputs at the falling edge, advance the reference at
  // the rising edge, return 1 time unit later so the caller can drive inputs.
  task automatic cycle();
    logic [N-1:0] exp_ready;
    int           g;
    @(negedge clk);
    exp_ready = '0;
    g = -1;
    if (rst_n === 1'b1 && m_phase != 1) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    check("rsp_valid", rsp_valid, (rst_n === 1'b1) && m_phase == 2);
    check("busy", busy, (rst_n === 1'b1) && m_phase != 0);
    if (rst_n === 1'b1 && m_phase == 2) begin
      check("rsp_id", rsp_id, m_id);
      check("rsp_data", rsp_data, m_data);
      check("rsp_overflow", rsp_overflow, m_ovf);
      last_id   = int'(rsp_id);
      last_data = rsp_data;
      last_ovf  = rsp_overflow;
    end
    @(posedge clk);
    if (rst_n === 1'b1) begin
      if (g >= 0) begin
        ref_op(req_a[g*W +: W], req_b[g*W +: W], req_sub[g], m_data, m_ovf);
        m_id    = g;
        m_ptr   = (g + 1) % N;
        m_phase = 1;
        grant_log.push_back(g);
      end else begin
        m_phase = (m_phase == 1) ? 2 : 0;
      end
    end
    #1;
  endtask

  // Single isolated operation from one requester, checked against constants.
  task automatic run_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] ed, input logic eo,
                        input string tag);
    last_id   = -1;
    last_data = 'x;
    last_ovf  = 1'bx;
    req_valid          = '0;
    req_valid[idx]     = 1'b1;
    req_a[idx*W +: W]  = a;
    req_b[idx*W +: W]  = b;
    req_sub[idx]       = sub;
    cycle();
    req_valid = '0;
    cycle();
    cycle();
    check({tag, "_id"}, last_id, idx);
    check({tag, "_data"}, last_data, ed);
    check({tag, "_ovf"}, last_ovf, eo);
  endtask

  initial begin
    int exp_all[8];
    int exp_drop[4];
    exp_all  = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_drop = '{0, 1, 3, 0};

    // Reset with random inputs applied.
    rst_n     = 1'b0;
    req_valid = N'($urandom);
    req_a     = {$urandom, $urandom};
    req_b     = {$urandom, $urandom};
    req_sub   = N'($urandom);
    cycle();
    check("reset_rsp_data", rsp_data, 16'h0000);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_ovf", rsp_overflow, 1'b0);
    cycle();
    req_valid = '0;
    rst_n     = 1'b1;
    cycle();

    // Directed corner operations.
    run_op(0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, "single_add");
    run_op(1, 16'h7FFF, 16'hFFFF, 1'b1, EXP_SUB_OVF, 1'b1, "sub_ovf");
    run_op(2, 16'h0000, 16'h8000, 1'b1, EXP_MIN_OVF, 1'b1, "min_pos_a");
    run_op(3, 16'hFFFF, 16'h8000, 1'b1, 16'h7FFF, 1'b0, "min_neg_a");

    // Fairness: all requesters held, then requester 2 withdrawn.
    grant_log.delete();
    req_valid = '1;
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < N; i++) begin
        req_a[i*W +: W] = pick();
        req_b[i*W +: W] = pick();
      end
      req_sub = N'($urandom);
      cycle();
    end
    check("fair_all_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check($sformatf("fair_all_%0d", i), grant_log[i], exp_all[i]);

    grant_log.delete();
    req_valid = 4'b1011;
    for (int c = 0; c < 8; c++) cycle();
    check("fair_drop_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check($sformatf("fair_drop_%0d", i), grant_log[i], exp_drop[i]);
    req_valid = '0;
    cycle();
    cycle();

    // Randomised traffic with requests appearing and vanishing.
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_a[i*W +: W] = pick();
        req_b[i*W +: W] = pick();
      end
      req_sub = N'($urandom);
      cycle();
    end
    req_valid = '0;
    cycle();
    cycle();
    cycle();

    // Reset while an operation is in flight.
    req_valid = '1;
    cycle();
    check("midrst_in_oper", busy, 1'b1);
    rst_n = 1'b0;
    m_phase = 0;
    m_ptr   = 0;
    #2;
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    cycle();
    cycle();
    rst_n = 1'b1;
    grant_log.delete();
    cycle();
    cycle();
    check("post_reset_accepts", grant_log.size(), 1);
    if (grant_log.size() > 0) check("post_reset_grant", grant_log[0], 0);
    req_valid = '0;
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
